// File: rtl/multicycle_control_unit.sv
// Multicycle controller: sequences IF/ID/EXE/MEM/WB from the latched opcode and
// drives datapath enables and mux selects combinationally from the current state.
module multicycle_control_unit #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned SW_ST = 3
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero,
    output logic [SW_ST-1:0] state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             mRD,
    output logic             mWR,
    output logic             DBDataSrc,
    output logic [1:0]       PCSrc
);

    typedef enum logic [SW_ST-1:0] {
        S_IF   = SW_ST'(0),
        S_ID   = SW_ST'(1),
        S_EXE  = SW_ST'(2),
        S_MEM  = SW_ST'(3),
        S_WB   = SW_ST'(4),
        S_HALT = SW_ST'(7)
    } state_e;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b110101);
    localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
    localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

    state_e     r_state;
    state_e     w_next;
    logic [2:0] w_aluop;
    logic       w_alusrcb;
    logic       w_extsel;
    logic       w_rtype;
    logic       w_itype;
    logic       w_branch;
    logic       w_taken;

    // Opcode decode shared by EXE and MEM (ALU controls are held through MEM)
    always_comb begin
        w_aluop   = 3'b000;
        w_alusrcb = 1'b0;
        w_extsel  = 1'b0;
        w_rtype   = 1'b0;
        w_itype   = 1'b0;
        w_branch  = 1'b0;
        case (opcode)
            OP_ADD:  w_rtype = 1'b1;
            OP_SUB:  begin w_rtype = 1'b1; w_aluop = 3'b001; end
            OP_OR:   begin w_rtype = 1'b1; w_aluop = 3'b011; end
            OP_AND:  begin w_rtype = 1'b1; w_aluop = 3'b100; end
            OP_SLT:  begin w_rtype = 1'b1; w_aluop = 3'b110; end
            OP_ADDI: begin w_itype = 1'b1; w_alusrcb = 1'b1; w_extsel = 1'b1; end
            OP_ORI:  begin w_itype = 1'b1; w_alusrcb = 1'b1; w_aluop = 3'b011; end
            OP_LW:   begin w_itype = 1'b1; w_alusrcb = 1'b1; w_extsel = 1'b1; end
            OP_SW:   begin w_alusrcb = 1'b1; w_extsel = 1'b1; end
            OP_BEQ,
            OP_BNE:  begin w_branch = 1'b1; w_aluop = 3'b001; w_extsel = 1'b1; end
            default: ;
        endcase
    end

    assign w_taken = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_state <= S_IF;
        else        r_state <= w_next;
    end

    assign state = r_state;

    // Next state and outputs; everything is forced low while reset is held
    always_comb begin
        w_next    = r_state;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        case (r_state)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
                w_next   = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_J:    begin PCSrc = 2'b11; PCWre = 1'b1; w_next = S_IF; end
                    OP_JR:   begin PCSrc = 2'b10; PCWre = 1'b1; w_next = S_IF; end
                    OP_JAL:  begin
                        PCSrc  = 2'b11;
                        PCWre  = 1'b1;
                        RegWre = 1'b1;
                        w_next = S_IF;
                    end
                    OP_HALT: w_next = S_HALT;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT,
                    OP_SW, OP_LW, OP_BEQ, OP_BNE: w_next = S_EXE;
                    default: begin PCWre = 1'b1; w_next = S_IF; end
                endcase
            end
            S_EXE: begin
                ALUOp   = w_aluop;
                ALUSrcB = w_alusrcb;
                ExtSel  = w_extsel;
                if (w_branch) begin
                    PCWre  = 1'b1;
                    PCSrc  = w_taken ? 2'b01 : 2'b00;
                    w_next = S_IF;
                end else if ((opcode == OP_SW) || (opcode == OP_LW)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                ALUOp   = w_aluop;
                ALUSrcB = w_alusrcb;
                ExtSel  = w_extsel;
                if (opcode == OP_SW) begin
                    mWR    = 1'b1;
                    PCWre  = 1'b1;
                    w_next = S_IF;
                end else if (opcode == OP_LW) begin
                    mRD    = 1'b1;
                    w_next = S_WB;
                end else begin
                    w_next = S_IF;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                w_next    = S_IF;
                if (w_rtype)      RegDst = 2'b10;
                else if (w_itype) RegDst = 2'b01;
                if (opcode == OP_LW) begin
                    DBDataSrc = 1'b1;
                    mRD       = 1'b1;
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
        if (!RST_n) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            InsMemRW  = 1'b0;
            RegWre    = 1'b0;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
            ALUSrcB   = 1'b0;
            ALUOp     = 3'b000;
            ExtSel    = 1'b0;
            mRD       = 1'b0;
            mWR       = 1'b0;
            DBDataSrc = 1'b0;
            PCSrc     = 2'b00;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues hand-computed
// output vectors per cycle, a monitor pops and compares them.
module tb_multicycle_control_unit;

    logic       CLK;
    logic       RST_n;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcB, ExtSel;
    logic       mRD, mWR, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    multicycle_control_unit #(.OPW(6), .SW_ST(3)) dut (
        .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    string       q_name[$];
    logic [19:0] q_exp[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    event        chk_ev;

    // {state,PCWre,IRWre,InsMemRW,RegWre,RegDst,WrRegDSrc,ALUSrcB,ALUOp,ExtSel,mRD,mWR,DBDataSrc,PCSrc}
    function automatic logic [19:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic imr, input logic rw, input logic [1:0] rd,
                                       input logic ws, input logic asb, input logic [2:0] aop,
                                       input logic ext, input logic mrd, input logic mwr,
                                       input logic dbs, input logic [1:0] pcs);
        return {st, pcw, irw, imr, rw, rd, ws, asb, aop, ext, mrd, mwr, dbs, pcs};
    endfunction

    // Monitor: compare every queued expectation against the live outputs
    initial begin
        string       nm;
        logic [19:0] e;
        logic [19:0] got;
        forever begin
            @(negedge CLK or chk_ev);
            while (q_exp.size() > 0) begin
                nm  = q_name.pop_front();
                e   = q_exp.pop_front();
                got = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcB,
                       ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %05h expected %05h (t=%0t)", nm, got, e, $time);
                end
            end
        end
    end

    // Drive one cycle's inputs and queue that cycle's expected outputs
    task automatic drive(input logic [5:0] op, input logic z, input string nm,
                         input logic [19:0] e);
        opcode = op;
        zero   = z;
        q_name.push_back(nm);
        q_exp.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    // Assert reset dly after the cycle start, check outputs at once, hold through the edge
    task automatic rst_pulse(input int dly, input string nm);
        #(dly);
        RST_n = 1'b0;
        #1;
        q_name.push_back(nm);
        q_exp.push_back(20'h0);
        ->chk_ev;
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v_if;
        logic [19:0] v_rst;
        logic [19:0] v_id;
        v_if  = mk(3'd0, 0, 1, 1, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);
        v_rst = 20'h0;
        v_id  = mk(3'd1, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00);
        RST_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) drive(6'b000000, 0, "reset_hold", v_rst);
        RST_n = 1'b1;

        // ADD
        drive(6'b000000, 0, "add_if", v_if);
        drive(6'b000000, 0, "add_id", v_id);
        drive(6'b000000, 0, "add_exe", mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        drive(6'b000000, 0, "add_wb", mk(3'd4, 1, 0, 0, 1, 2'b10, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        // LW
        drive(6'b110001, 0, "lw_if", v_if);
        drive(6'b110001, 0, "lw_id", v_id);
        drive(6'b110001, 0, "lw_exe", mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000, 1, 0, 0, 0, 2'b00));
        drive(6'b110001, 1, "lw_mem", mk(3'd3, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000, 1, 1, 0, 0, 2'b00));
        drive(6'b110001, 0, "lw_wb", mk(3'd4, 1, 0, 0, 1, 2'b01, 1, 0, 3'b000, 0, 1, 0, 1, 2'b00));
        // ORI: zero-extended immediate, rt destination
        drive(6'b010010, 0, "ori_if", v_if);
        drive(6'b010010, 0, "ori_id", v_id);
        drive(6'b010010, 0, "ori_exe", mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 3'b011, 0, 0, 0, 0, 2'b00));
        drive(6'b010010, 0, "ori_wb", mk(3'd4, 1, 0, 0, 1, 2'b01, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        // BEQ taken / not taken, BNE taken
        drive(6'b110100, 0, "beq1_if", v_if);
        drive(6'b110100, 0, "beq1_id", v_id);
        drive(6'b110100, 1, "beq1_exe", mk(3'd2, 1, 0, 0, 0, 2'b00, 0, 0, 3'b001, 1, 0, 0, 0, 2'b01));
        drive(6'b110100, 0, "beq0_if", v_if);
        drive(6'b110100, 1, "beq0_id", v_id);
        drive(6'b110100, 0, "beq0_exe", mk(3'd2, 1, 0, 0, 0, 2'b00, 0, 0, 3'b001, 1, 0, 0, 0, 2'b00));
        drive(6'b110101, 0, "bne0_if", v_if);
        drive(6'b110101, 0, "bne0_id", v_id);
        drive(6'b110101, 0, "bne0_exe", mk(3'd2, 1, 0, 0, 0, 2'b00, 0, 0, 3'b001, 1, 0, 0, 0, 2'b01));
        // JAL, J, JR: two-cycle instructions
        drive(6'b111010, 0, "jal_if", v_if);
        drive(6'b111010, 0, "jal_id", mk(3'd1, 1, 0, 0, 1, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b11));
        drive(6'b111000, 0, "j_if", v_if);
        drive(6'b111000, 0, "j_id", mk(3'd1, 1, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b11));
        drive(6'b111001, 0, "jr_if", v_if);
        drive(6'b111001, 0, "jr_id", mk(3'd1, 1, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b10));
        // HALT holds, then asynchronous reset mid-cycle
        drive(6'b111111, 0, "halt_if", v_if);
        drive(6'b111111, 0, "halt_id", v_id);
        for (int i = 0; i < 10; i++)
            drive(6'b111111, i[0], "halt_hold", mk(3'd7, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        rst_pulse(2, "halt_async_rst");
        // SW with reset during MEM
        drive(6'b110000, 0, "sw_if", v_if);
        drive(6'b110000, 0, "sw_id", v_id);
        drive(6'b110000, 0, "sw_exe", mk(3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000, 1, 0, 0, 0, 2'b00));
        q_name.push_back("sw_mem");
        q_exp.push_back(mk(3'd3, 1, 0, 0, 0, 2'b00, 0, 1, 3'b000, 1, 0, 1, 0, 2'b00));
        rst_pulse(6, "sw_mem_async_rst");
        // Undefined opcode treated as NOP
        drive(6'b101010, 0, "undef_if", v_if);
        drive(6'b101010, 0, "undef_id", mk(3'd1, 1, 0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        drive(6'b000001, 0, "after_undef_if", v_if);

        @(negedge CLK);
        #1;
        if (q_exp.size() != 0) begin
            n_fail += q_exp.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
